univ_shift_reg: RTL and testbench

//  Parametrised universal shift register: hold, shift L/R, rotate L/R, parallel

---
 rtl/univ_shift_reg.sv | 113 +++++++++++
 tb/tb_univ_shift_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift/rotate left/right, parallel load and clear,
// with a shift counter that pulses frame_done on every WIDTH-th shift.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             si_l,
  input  logic             si_r,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             so,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHL   = 3'b001,
    M_SHR   = 3'b010,
    M_ROL   = 3'b011,
    M_ROR   = 3'b100,
    M_LOAD  = 3'b101,
    M_CLEAR = 3'b110,
    M_RSVD  = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mode_e            op;
  logic [WIDTH-1:0] pout_nxt;
  logic             so_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             fd_nxt;
  logic             shift;

  assign op = mode_e'(mode);

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    pout_nxt = pout;
    so_nxt   = so;
    cnt_nxt  = cnt;
    fd_nxt   = 1'b0;
    shift    = 1'b0;
    if (en) begin
      case (op)
        M_SHL: begin
          pout_nxt = {pout[WIDTH-2:0], si_l};
          so_nxt   = pout[WIDTH-1];
          shift    = 1'b1;
        end
        M_SHR: begin
          pout_nxt = {si_r, pout[WIDTH-1:1]};
          so_nxt   = pout[0];
          shift    = 1'b1;
        end
        M_ROL: begin
          pout_nxt = {pout[WIDTH-2:0], pout[WIDTH-1]};
          so_nxt   = pout[WIDTH-1];
          shift    = 1'b1;
        end
        M_ROR: begin
          pout_nxt = {pout[0], pout[WIDTH-1:1]};
          so_nxt   = pout[0];
          shift    = 1'b1;
        end
        M_LOAD: begin
          pout_nxt = pin;
          cnt_nxt  = '0;
        end
        M_CLEAR: begin
          pout_nxt = '0;
          so_nxt   = 1'b0;
          cnt_nxt  = '0;
        end
        default: ;  // HOLD and the reserved code leave everything as is
      endcase
    end

    // Counting happens only on a real shift, so LOAD/CLEAR pre-empt the wrap.
    if (shift) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = '0;
        fd_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pout       <= RST_VAL;
      so         <= 1'b0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values of its neighbours.
      pout       <= pout_nxt;
      so         <= so_nxt;
      cnt        <= cnt_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: three instances (WIDTH 8, 2, 16) share
// the control inputs; each scenario task checks its own hand-computed results.
module tb_univ_shift_reg;

  localparam logic [2:0] HOLD = 3'b000, SHL = 3'b001, SHR = 3'b010, ROL = 3'b011,
                         ROR = 3'b100, LOAD = 3'b101, CLR = 3'b110, RSVD = 3'b111;
  localparam logic [7:0] RV8 = 8'h96;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  mode = HOLD;
  logic        si_l = 1'b0;
  logic        si_r = 1'b0;

  logic [7:0]  pin8 = '0, pout8;
  logic        so8, fd8;
  logic [3:0]  cnt8;
  logic [1:0]  pin2 = '0, pout2;
  logic        so2, fd2;
  logic [1:0]  cnt2;
  logic [15:0] pin16 = '0, pout16;
  logic        so16, fd16;
  logic [4:0]  cnt16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(RV8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .si_l(si_l), .si_r(si_r),
    .pin(pin8), .pout(pout8), .so(so8), .cnt(cnt8), .frame_done(fd8));

  univ_shift_reg #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .si_l(si_l), .si_r(si_r),
    .pin(pin2), .pout(pout2), .so(so2), .cnt(cnt2), .frame_done(fd2));

  univ_shift_reg #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .si_l(si_l), .si_r(si_r),
    .pin(pin16), .pout(pout16), .so(so16), .cnt(cnt16), .frame_done(fd16));

  // One clock with the given controls; returns 1 time unit after the edge.
  task automatic op(input logic [2:0] m, input logic sl, input logic sr, input logic e);
    mode = m; si_l = sl; si_r = sr; en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (pout8 !== RV8) begin errors++; $display("FAIL reset_pout8 got=%h exp=%h", pout8, RV8); end
    checks++; if (so8 !== 1'b0) begin errors++; $display("FAIL reset_so8 got=%b exp=0", so8); end
    checks++; if (cnt8 !== 4'd0) begin errors++; $display("FAIL reset_cnt8 got=%0d exp=0", cnt8); end
    checks++; if (fd8 !== 1'b0) begin errors++; $display("FAIL reset_fd8 got=%b exp=0", fd8); end
    checks++; if (pout2 !== 2'b00 || pout16 !== 16'h0) begin
      errors++; $display("FAIL reset_pout_w2_w16 got=%h/%h exp=0/0", pout2, pout16); end
    op(SHL, 1'b1, 1'b1, 1'b1);  // held in reset despite an enabled shift
    checks++; if (pout8 !== RV8 || cnt8 !== 4'd0) begin
      errors++; $display("FAIL reset_held got=%h/%0d exp=%h/0", pout8, cnt8, RV8); end
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
  endtask

  task automatic test_shl_serialise();
    logic [7:0] so_exp;
    so_exp = 8'hA5;
    pin8 = 8'hA5;
    op(LOAD, 1'b0, 1'b0, 1'b1);
    checks++; if (pout8 !== 8'hA5 || cnt8 !== 4'd0) begin
      errors++; $display("FAIL shl_load got=%h/%0d exp=a5/0", pout8, cnt8); end
    for (int i = 0; i < 8; i++) begin
      op(SHL, 1'b0, 1'b1, 1'b1);
      checks++; if (so8 !== so_exp[7-i]) begin
        errors++; $display("FAIL shl_so[%0d] got=%b exp=%b", i, so8, so_exp[7-i]); end
      checks++; if (fd8 !== (i == 7)) begin
        errors++; $display("FAIL shl_fd[%0d] got=%b exp=%b", i, fd8, (i == 7)); end
      checks++; if (cnt8 !== 4'((i + 1) % 8)) begin
        errors++; $display("FAIL shl_cnt[%0d] got=%0d exp=%0d", i, cnt8, (i + 1) % 8); end
    end
    checks++; if (pout8 !== 8'h00) begin errors++; $display("FAIL shl_final_pout got=%h exp=00", pout8); end
  endtask

  task automatic test_ror();
    int pulses;
    pulses = 0;
    pin8 = 8'h81;
    op(LOAD, 1'b0, 1'b0, 1'b1);
    op(ROR, 1'b1, 1'b1, 1'b1);
    checks++; if (pout8 !== 8'hC0 || so8 !== 1'b1 || cnt8 !== 4'd1) begin
      errors++; $display("FAIL ror_first got=%h/%b/%0d exp=c0/1/1", pout8, so8, cnt8); end
    for (int i = 0; i < 7; i++) begin
      op(ROR, 1'b1, 1'b1, 1'b1);
      if (fd8) pulses++;
    end
    checks++; if (pout8 !== 8'h81 || fd8 !== 1'b1) begin
      errors++; $display("FAIL ror_frame got=%h/%b exp=81/1", pout8, fd8); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ror_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_shr_enable();
    op(CLR, 1'b0, 1'b0, 1'b1);
    checks++; if (pout8 !== 8'h00 || so8 !== 1'b0 || cnt8 !== 4'd0) begin
      errors++; $display("FAIL clear got=%h/%b/%0d exp=00/0/0", pout8, so8, cnt8); end
    for (int i = 0; i < 3; i++) op(SHR, 1'b1, 1'b1, 1'b1);
    checks++; if (pout8 !== 8'hE0 || cnt8 !== 4'd3 || so8 !== 1'b0) begin
      errors++; $display("FAIL shr3 got=%h/%0d/%b exp=e0/3/0", pout8, cnt8, so8); end
    for (int i = 0; i < 4; i++) begin
      op(SHR, 1'b1, 1'b1, 1'b0);
      checks++; if (pout8 !== 8'hE0 || cnt8 !== 4'd3 || so8 !== 1'b0 || fd8 !== 1'b0) begin
        errors++; $display("FAIL en_low[%0d] got=%h/%0d/%b/%b exp=e0/3/0/0", i, pout8, cnt8, so8, fd8); end
    end
  endtask

  task automatic test_load_preempt();
    pin8 = 8'h3C;
    op(LOAD, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) op(SHL, 1'b0, 1'b0, 1'b1);
    checks++; if (cnt8 !== 4'd7 || pout8 !== 8'h00) begin
      errors++; $display("FAIL pre_load_state got=%h/%0d exp=00/7", pout8, cnt8); end
    pin8 = 8'hFF;
    op(LOAD, 1'b0, 1'b0, 1'b1);
    checks++; if (pout8 !== 8'hFF || cnt8 !== 4'd0 || fd8 !== 1'b0) begin
      errors++; $display("FAIL load_preempt got=%h/%0d/%b exp=ff/0/0", pout8, cnt8, fd8); end
  endtask

  task automatic test_async_reset_rsvd();
    pin8 = 8'h3C;
    op(LOAD, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) op(SHL, 1'b0, 1'b0, 1'b1);
    checks++; if (cnt8 !== 4'd5 || so8 !== 1'b1) begin
      errors++; $display("FAIL mid_frame got=%0d/%b exp=5/1", cnt8, so8); end
    #3 rst = 1'b0;
    #1;
    checks++; if (pout8 !== RV8 || so8 !== 1'b0 || cnt8 !== 4'd0 || fd8 !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%h/%b/%0d/%b exp=%h/0/0/0", pout8, so8, cnt8, fd8, RV8); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op(RSVD, 1'b1, 1'b1, 1'b1);
      checks++; if (pout8 !== RV8 || cnt8 !== 4'd0 || fd8 !== 1'b0) begin
        errors++; $display("FAIL rsvd_after_reset[%0d] got=%h/%0d exp=%h/0", i, pout8, cnt8, RV8); end
    end
    pin8 = 8'h5A;
    op(LOAD, 1'b0, 1'b0, 1'b1);
    op(SHL, 1'b1, 1'b0, 1'b1);
    checks++; if (pout8 !== 8'hB5 || so8 !== 1'b0 || cnt8 !== 4'd1) begin
      errors++; $display("FAIL shl_si got=%h/%b/%0d exp=b5/0/1", pout8, so8, cnt8); end
    op(RSVD, 1'b0, 1'b1, 1'b1);
    op(HOLD, 1'b1, 1'b0, 1'b1);
    checks++; if (pout8 !== 8'hB5 || so8 !== 1'b0 || cnt8 !== 4'd1 || fd8 !== 1'b0) begin
      errors++; $display("FAIL rsvd_hold got=%h/%b/%0d/%b exp=b5/0/1/0", pout8, so8, cnt8, fd8); end
  endtask

  // 16 ROL then 16 SHR across all widths: counters run straight through the
  // direction change and each frame_done recurs every WIDTH shifts.
  task automatic test_widths_back_to_back();
    pin8 = 8'h81; pin2 = 2'b10; pin16 = 16'hA5C3;
    op(LOAD, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      op((i < 16) ? ROL : SHR, 1'b1, 1'b0, 1'b1);
      checks++; if (cnt2 !== 2'((i + 1) % 2) || fd2 !== ((i + 1) % 2 == 0)) begin
        errors++; $display("FAIL w2[%0d] cnt/fd got=%0d/%b exp=%0d/%b", i, cnt2, fd2, (i + 1) % 2, ((i + 1) % 2 == 0)); end
      checks++; if (cnt8 !== 4'((i + 1) % 8) || fd8 !== ((i + 1) % 8 == 0)) begin
        errors++; $display("FAIL w8[%0d] cnt/fd got=%0d/%b exp=%0d/%b", i, cnt8, fd8, (i + 1) % 8, ((i + 1) % 8 == 0)); end
      checks++; if (cnt16 !== 5'((i + 1) % 16) || fd16 !== ((i + 1) % 16 == 0)) begin
        errors++; $display("FAIL w16[%0d] cnt/fd got=%0d/%b exp=%0d/%b", i, cnt16, fd16, (i + 1) % 16, ((i + 1) % 16 == 0)); end
      if (i == 15) begin
        checks++; if (pout2 !== 2'b10 || pout8 !== 8'h81 || pout16 !== 16'hA5C3) begin
          errors++; $display("FAIL rol_restore got=%h/%h/%h exp=2/81/a5c3", pout2, pout8, pout16); end
      end
    end
    checks++; if (pout2 !== 2'b00 || pout8 !== 8'h00 || pout16 !== 16'h0000) begin
      errors++; $display("FAIL shr_drain got=%h/%h/%h exp=0/00/0000", pout2, pout8, pout16); end
  endtask

  initial begin
    test_reset();
    test_shl_serialise();
    test_ror();
    test_shr_enable();
    test_load_preempt();
    test_async_reset_rsvd();
    test_widths_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
